// File: rtl/cpu_intr_pkg.sv
// Shared types and helpers for the interrupt controller (intr_ctrl).
package cpu_intr_pkg;

  localparam int unsigned N_IRQ_DEF = 8;
  localparam int unsigned VEC_W     = 32;
  localparam int unsigned IDX_W     = 5;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } intr_state_e;

  // Result of a lowest-set-bit search
  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } lowest_t;

  // Index of the lowest set bit (highest priority), plus a found flag
  function automatic lowest_t lowest_one(input logic [VEC_W-1:0] vec);
    lowest_t r;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = VEC_W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.found = 1'b1;
        r.idx   = IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/intr_sync.sv
// Two-flop synchroniser per line with rising-edge detect on the synchronised value.
module intr_sync #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic [W-1:0] prev_q;

  // Synchroniser chain plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: latches IRQs, picks the highest-priority eligible one
// against the in-service register, and hands it to uc with a req/ack handshake.
// Optional macro INTR_MASK_EN adds a per-channel mask register (mask_we/mask_d).
module intr_ctrl
  import cpu_intr_pkg::*;
#(
  parameter int unsigned      N_IRQ     = N_IRQ_DEF,
  parameter logic [N_IRQ-1:0] EDGE_MASK = '1,
  localparam int unsigned     ID_W      = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             intr_ack,
  input  logic             intr_ret,
`ifdef INTR_MASK_EN
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_d,
`endif
  output logic             intr_req,
  output logic [ID_W-1:0]  intr_id,
  output logic [N_IRQ-1:0] intr_vec,
  output logic [N_IRQ-1:0] ret_vec,
  output logic [N_IRQ-1:0] isr,
  output logic [N_IRQ-1:0] pending
);

  intr_state_e      state_q, state_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [N_IRQ-1:0] vec_q, vec_d;
  logic [N_IRQ-1:0] isr_q, isr_d;
  logic [N_IRQ-1:0] edge_q, edge_d;
  logic [N_IRQ-1:0] sync_lvl, sync_rise;
  logic [N_IRQ-1:0] mask_en;
  logic [N_IRQ-1:0] ack_vec;
  logic             ack_fire;
  logic             eligible;
  lowest_t          pend_lo, isr_lo;

  intr_sync #(.W(N_IRQ)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (irq),
    .q_o    (sync_lvl),
    .rise_o (sync_rise)
  );

`ifdef INTR_MASK_EN
  logic [N_IRQ-1:0] mask_q;

  // Channel enable register; all channels enabled out of reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mask_q <= '1;
    else if (mask_we) mask_q <= mask_d;
  end

  assign mask_en = mask_q;
`else
  assign mask_en = '1;
`endif

  // Edge channels come from the latch, level channels straight from the synchroniser
  assign pending  = ((edge_q & EDGE_MASK) | (sync_lvl & ~EDGE_MASK)) & mask_en;
  assign pend_lo  = lowest_one(VEC_W'(pending));
  assign isr_lo   = lowest_one(VEC_W'(isr_q));
  assign eligible = pend_lo.found && (!isr_lo.found || (pend_lo.idx < isr_lo.idx));
  assign ack_fire = intr_ack && (state_q == REQ);

  // Return decode: lowest in-service bit, only in the intr_ret cycle
  always_comb begin
    ret_vec = '0;
    if (intr_ret && isr_lo.found) ret_vec = N_IRQ'(1) << isr_lo.idx;
  end

  // ISR and edge-latch update; ret clears before ack sets, edge set beats ack clear
  always_comb begin
    ack_vec = '0;
    if (ack_fire) ack_vec = N_IRQ'(1) << id_q;
    isr_d  = (isr_q & ~ret_vec) | ack_vec;
    edge_d = ((edge_q & ~ack_vec) | sync_rise) & EDGE_MASK;
  end

  // Handshake FSM next state; id and one-hot frozen for the whole request
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    vec_d   = vec_q;
    unique case (state_q)
      IDLE: begin
        if (eligible) begin
          state_d = REQ;
          id_d    = ID_W'(pend_lo.idx);
          vec_d   = N_IRQ'(1) << pend_lo.idx;
        end
      end
      REQ: begin
        if (intr_ack) begin
          state_d = IDLE;
          vec_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      vec_q   <= '0;
      isr_q   <= '0;
      edge_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      vec_q   <= vec_d;
      isr_q   <= isr_d;
      edge_q  <= edge_d;
    end
  end

  assign intr_req = (state_q == REQ);
  assign intr_id  = id_q;
  assign intr_vec = vec_q;
  assign isr      = isr_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: per-cycle vector table plus hand-written corner sequences.
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq, irq2;
  logic       ack, ret, ack2, ret2;
  logic       req, req2;
  logic [2:0] id, id2;
  logic [7:0] vec, vec2, retv, retv2, isr, isr2, pend, pend2;
`ifdef INTR_MASK_EN
  logic       mask_we;
  logic [7:0] mask_d;
  logic       mask_we2;
  logic [7:0] mask_d2;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  intr_ctrl #(.N_IRQ(8), .EDGE_MASK(8'hFF)) u_dut (
    .clk(clk), .reset(reset), .irq(irq), .intr_ack(ack), .intr_ret(ret),
`ifdef INTR_MASK_EN
    .mask_we(mask_we), .mask_d(mask_d),
`endif
    .intr_req(req), .intr_id(id), .intr_vec(vec), .ret_vec(retv),
    .isr(isr), .pending(pend)
  );

  intr_ctrl #(.N_IRQ(8), .EDGE_MASK(8'hFE)) u_lvl (
    .clk(clk), .reset(reset), .irq(irq2), .intr_ack(ack2), .intr_ret(ret2),
`ifdef INTR_MASK_EN
    .mask_we(mask_we2), .mask_d(mask_d2),
`endif
    .intr_req(req2), .intr_id(id2), .intr_vec(vec2), .ret_vec(retv2),
    .isr(isr2), .pending(pend2)
  );

  typedef struct {
    logic [7:0] irq;
    logic       ack;
    logic       ret;
    logic [7:0] e_retv;
    logic       e_req;
    logic [2:0] e_id;
    logic [7:0] e_vec;
    logic [7:0] e_isr;
    logic [7:0] e_pend;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for a request on either instance
  task automatic wait_req(input bit lvl, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      seen = lvl ? req2 : req;
    end
  endtask

  task automatic add(input logic [7:0] i, input logic a, input logic r, input logic [7:0] rv,
                     input logic q, input logic [2:0] d, input logic [7:0] v,
                     input logic [7:0] s, input logic [7:0] p);
    vec_t t;
    t.irq = i; t.ack = a; t.ret = r; t.e_retv = rv; t.e_req = q;
    t.e_id = d; t.e_vec = v; t.e_isr = s; t.e_pend = p;
    tbl.push_back(t);
  endtask

  initial begin
    bit seen;
    bit any;

    reset = 1'b0;
    irq = '0; ack = 0; ret = 0; irq2 = '0; ack2 = 0; ret2 = 0;
`ifdef INTR_MASK_EN
    mask_we = 0; mask_d = '1; mask_we2 = 0; mask_d2 = '1;
`endif

    //       irq  ack ret retv req id vec  isr  pend
    add(8'h20, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00); // pulse irq5
    add(8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h20); // 3 clk latency
    add(8'h00, 0, 0, 8'h00, 1, 5, 8'h20, 8'h00, 8'h20);
    add(8'h00, 1, 0, 8'h00, 0, 5, 8'h00, 8'h20, 8'h00); // ack
    add(8'h44, 0, 0, 8'h00, 0, 5, 8'h00, 8'h20, 8'h00); // pulse irq2+irq6
    add(8'h00, 0, 0, 8'h00, 0, 5, 8'h00, 8'h20, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 5, 8'h00, 8'h20, 8'h44);
    add(8'h00, 0, 0, 8'h00, 1, 2, 8'h04, 8'h20, 8'h44); // nests
    add(8'h00, 1, 0, 8'h00, 0, 2, 8'h00, 8'h24, 8'h40);
    add(8'h00, 0, 0, 8'h00, 0, 2, 8'h00, 8'h24, 8'h40);
    add(8'h00, 0, 1, 8'h04, 0, 2, 8'h00, 8'h20, 8'h40); // ret clears bit2
    add(8'h00, 0, 0, 8'h00, 0, 2, 8'h00, 8'h20, 8'h40);
    add(8'h00, 0, 1, 8'h20, 0, 2, 8'h00, 8'h00, 8'h40); // ret clears bit5
    add(8'h00, 0, 0, 8'h00, 1, 6, 8'h40, 8'h00, 8'h40); // irq6 now served
    add(8'h00, 1, 0, 8'h00, 0, 6, 8'h00, 8'h40, 8'h00);
    add(8'h00, 0, 1, 8'h40, 0, 6, 8'h00, 8'h00, 8'h00);
    add(8'h08, 0, 0, 8'h00, 0, 6, 8'h00, 8'h00, 8'h00); // irq3 first pulse
    add(8'h00, 0, 0, 8'h00, 0, 6, 8'h00, 8'h00, 8'h00);
    add(8'h08, 0, 0, 8'h00, 0, 6, 8'h00, 8'h00, 8'h08); // second pulse
    add(8'h00, 0, 0, 8'h00, 1, 3, 8'h08, 8'h00, 8'h08);
    add(8'h00, 1, 0, 8'h00, 0, 3, 8'h00, 8'h08, 8'h08); // set beats ack clear
    add(8'h00, 0, 0, 8'h00, 0, 3, 8'h00, 8'h08, 8'h08); // no self-preemption
    add(8'h00, 0, 1, 8'h08, 0, 3, 8'h00, 8'h00, 8'h08);
    add(8'h00, 0, 0, 8'h00, 1, 3, 8'h08, 8'h00, 8'h08);
    add(8'h00, 1, 0, 8'h00, 0, 3, 8'h00, 8'h08, 8'h00);
    add(8'h00, 0, 1, 8'h08, 0, 3, 8'h00, 8'h00, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 3, 8'h00, 8'h00, 8'h00);

    // Reset state
    step();
    step();
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_id", 32'(id), 32'd0);
    chk("rst_vec", 32'(vec), 32'd0);
    chk("rst_isr", 32'(isr), 32'd0);
    chk("rst_pend", 32'(pend), 32'd0);
    chk("rst_retv", 32'(retv), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Vector table on the all-edge instance
    foreach (tbl[n]) begin
      irq = tbl[n].irq;
      ack = tbl[n].ack;
      ret = tbl[n].ret;
      #1;
      chk($sformatf("tbl%0d_retv", n), 32'(retv), 32'(tbl[n].e_retv));
      step();
      chk($sformatf("tbl%0d_req", n), 32'(req), 32'(tbl[n].e_req));
      if (tbl[n].e_req) chk($sformatf("tbl%0d_id", n), 32'(id), 32'(tbl[n].e_id));
      chk($sformatf("tbl%0d_vec", n), 32'(vec), 32'(tbl[n].e_vec));
      chk($sformatf("tbl%0d_isr", n), 32'(isr), 32'(tbl[n].e_isr));
      chk($sformatf("tbl%0d_pend", n), 32'(pend), 32'(tbl[n].e_pend));
    end
    irq = '0; ack = 0; ret = 0;

    // Level channel 0: held high, ack, no re-request while in service
    irq2 = 8'h01;
    wait_req(1'b1, seen);
    chk("lvl_req", 32'(seen), 32'd1);
    chk("lvl_id", 32'(id2), 32'd0);
    chk("lvl_vec", 32'(vec2), 32'h01);
    ack2 = 1; step(); ack2 = 0;
    chk("lvl_isr", 32'(isr2), 32'h01);
    chk("lvl_pend_held", 32'(pend2), 32'h01);
    any = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      any = any | req2;
    end
    chk("lvl_no_rereq", 32'(any), 32'd0);
    irq2 = '0;
    repeat (3) step();
    chk("lvl_pend_drop", 32'(pend2), 32'h00);
    ret2 = 1; #1;
    chk("lvl_retv", 32'(retv2), 32'h01);
    step(); ret2 = 0;
    chk("lvl_isr_clr", 32'(isr2), 32'h00);
    any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      any = any | req2;
    end
    chk("lvl_no_req_after", 32'(any), 32'd0);

    // Same-cycle ack+ret with isr=8'h10 and channel 0 requesting
    irq2 = 8'h10; step(); irq2 = '0;
    wait_req(1'b1, seen);
    chk("ar_req4", 32'(seen), 32'd1);
    chk("ar_id4", 32'(id2), 32'd4);
    ack2 = 1; step(); ack2 = 0;
    chk("ar_isr10", 32'(isr2), 32'h10);
    irq2 = 8'h01;
    wait_req(1'b1, seen);
    chk("ar_req0", 32'(seen), 32'd1);
    chk("ar_id0", 32'(id2), 32'd0);
    ack2 = 1; ret2 = 1; #1;
    chk("ar_retv", 32'(retv2), 32'h10);
    step(); ack2 = 0; ret2 = 0;
    chk("ar_isr01", 32'(isr2), 32'h01);
    chk("ar_req_low", 32'(req2), 32'd0);
    irq2 = '0;
    repeat (3) step();
    ret2 = 1; step(); ret2 = 0;
    chk("ar_isr_end", 32'(isr2), 32'h00);

`ifdef INTR_MASK_EN
    // Masked edge stays latched and fires once unmasked
    mask_d = 8'hFB; mask_we = 1; step(); mask_we = 0;
    irq = 8'h04; step(); irq = '0;
    any = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      any = any | req;
    end
    chk("msk_no_req", 32'(any), 32'd0);
    chk("msk_pend_hidden", 32'(pend), 32'h00);
    mask_d = 8'hFF; mask_we = 1; step(); mask_we = 0;
    chk("msk_pend_visible", 32'(pend), 32'h04);
    chk("msk_req_not_yet", 32'(req), 32'd0);
    step();
    chk("msk_req", 32'(req), 32'd1);
    chk("msk_id", 32'(id), 32'd2);
    ack = 1; step(); ack = 0;
    chk("msk_isr", 32'(isr), 32'h04);
    ret = 1; step(); ret = 0;
    chk("msk_isr_clr", 32'(isr), 32'h00);
`endif

    // Asynchronous reset while a nested request is outstanding
    irq = 8'h10; step(); irq = '0;
    wait_req(1'b0, seen);
    chk("rr_req4", 32'(seen), 32'd1);
    ack = 1; step(); ack = 0;
    irq = 8'h02; step(); irq = '0;
    wait_req(1'b0, seen);
    chk("rr_req1", 32'(seen), 32'd1);
    chk("rr_isr_pre", 32'(isr), 32'h10);
    #2 reset = 1'b0;
    #1;
    chk("rr_req", 32'(req), 32'd0);
    chk("rr_id", 32'(id), 32'd0);
    chk("rr_vec", 32'(vec), 32'd0);
    chk("rr_isr", 32'(isr), 32'd0);
    chk("rr_pend", 32'(pend), 32'd0);
    chk("rr_retv", 32'(retv), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) step();
    chk("rr_isr_after", 32'(isr), 32'd0);
    chk("rr_req_after", 32'(req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
